// File: rtl/oled_frame_sequencer_pkg.sv
// Shared constants and state encoding for the SSD1306 byte sequencer.
package oled_frame_sequencer_pkg;

    localparam logic [6:0]  I2C_ADDR  = 7'h3C;
    localparam int unsigned INIT_LEN  = 26;
    localparam int unsigned ADDR_LEN  = 6;
    localparam int unsigned CMD_LEN   = INIT_LEN + ADDR_LEN;
    localparam int unsigned FB_BYTES  = 512;
    localparam int unsigned FB_AW     = 9;
    localparam int unsigned IDX_W     = 10;
    localparam int unsigned ROM_AW    = 5;
    localparam int unsigned LAST_IDX  = CMD_LEN + FB_BYTES - 1;

    localparam logic [7:0]  CTRL_CMD  = 8'h00;
    localparam logic [7:0]  CTRL_DATA = 8'h40;
    localparam logic [7:0]  RST_BYTE  = 8'hAE;

    // S_CMD: idle after reset, showing the first init command.
    // S_FETCH: framebuffer read in flight (strobe cycle, then data cycle).
    // S_HOLD: byte presented, waiting for the next index.
    typedef enum logic [1:0] {
        S_CMD   = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/oled_cmd_rom.sv
// Combinational lookup of the 26 init commands followed by the 6 addressing commands.
module oled_cmd_rom
    import oled_frame_sequencer_pkg::*;
(
    input  logic [ROM_AW-1:0] i_idx,
    output logic [7:0]        o_byte
);

    // Index-to-byte table
    always_comb begin
        o_byte = 8'h00;
        case (i_idx)
            5'd0:  o_byte = 8'hAE;
            5'd1:  o_byte = 8'hD5;
            5'd2:  o_byte = 8'h80;
            5'd3:  o_byte = 8'hA8;
            5'd4:  o_byte = 8'h1F;
            5'd5:  o_byte = 8'hD3;
            5'd6:  o_byte = 8'h00;
            5'd7:  o_byte = 8'h40;
            5'd8:  o_byte = 8'h8D;
            5'd9:  o_byte = 8'h14;
            5'd10: o_byte = 8'h20;
            5'd11: o_byte = 8'h00;
            5'd12: o_byte = 8'hA1;
            5'd13: o_byte = 8'hC8;
            5'd14: o_byte = 8'hDA;
            5'd15: o_byte = 8'h02;
            5'd16: o_byte = 8'h81;
            5'd17: o_byte = 8'h8F;
            5'd18: o_byte = 8'hD9;
            5'd19: o_byte = 8'hF1;
            5'd20: o_byte = 8'hDB;
            5'd21: o_byte = 8'h40;
            5'd22: o_byte = 8'hA4;
            5'd23: o_byte = 8'hA6;
            5'd24: o_byte = 8'h2E;
            5'd25: o_byte = 8'hAF;
            5'd26: o_byte = 8'h21;
            5'd27: o_byte = 8'h00;
            5'd28: o_byte = 8'h7F;
            5'd29: o_byte = 8'h22;
            5'd30: o_byte = 8'h00;
            5'd31: o_byte = 8'h03;
            default: o_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/oled_frame_sequencer.sv
// Maps the I2C master's acked-byte index to the next control/data byte for the OLED.
module oled_frame_sequencer
    import oled_frame_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_enable,
    input  logic [IDX_W-1:0] i_data_counter,
    output logic [6:0]       o_addr_byte,
    output logic             o_read_write,
    output logic [7:0]       o_control_byte,
    output logic [7:0]       o_data_byte,
    output logic             o_continue_bit,
    output logic             o_fb_rd_en,
    output logic [FB_AW-1:0] o_fb_rd_addr,
    input  logic [7:0]       i_fb_rd_data,
    output logic             o_init_done,
    output logic             o_frame_done,
    output logic             o_seq_err
);

    state_t             r_state,        w_state_nxt;
    logic [IDX_W-1:0]   r_idx_q,        w_idx_nxt;
    logic [7:0]         r_data_byte,    w_data_nxt;
    logic [7:0]         r_control_byte, w_ctrl_nxt;
    logic               r_fb_rd_en,     w_rd_en_nxt;
    logic [FB_AW-1:0]   r_fb_rd_addr,   w_rd_addr_nxt;
    logic               r_init_done,    w_init_nxt;
    logic               r_frame_done,   w_frame_nxt;
    logic               r_seq_err,      w_err_nxt;
    logic               r_continue_bit;
    logic [7:0]         w_rom_byte;
    logic               w_changed;

    oled_cmd_rom u_cmd_rom (
        .i_idx  (i_data_counter[ROM_AW-1:0]),
        .o_byte (w_rom_byte)
    );

    assign w_changed = (i_data_counter != r_idx_q);

    // Next-state and next-output decode; a fresh index always overrides a pending fetch
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx_q;
        w_data_nxt    = r_data_byte;
        w_ctrl_nxt    = r_control_byte;
        w_rd_en_nxt   = 1'b0;
        w_rd_addr_nxt = r_fb_rd_addr;
        w_init_nxt    = r_init_done;
        w_frame_nxt   = 1'b0;
        w_err_nxt     = 1'b0;

        if (w_changed) begin
            w_idx_nxt = i_data_counter;
            if (i_data_counter >= IDX_W'(INIT_LEN)) begin
                w_init_nxt = 1'b1;
            end
            if ((r_idx_q == IDX_W'(LAST_IDX)) && (i_data_counter == IDX_W'(INIT_LEN))) begin
                w_frame_nxt = 1'b1;
            end else if ((i_data_counter != (r_idx_q + IDX_W'(1))) ||
                         (i_data_counter > IDX_W'(LAST_IDX))) begin
                w_err_nxt = 1'b1;
            end

            if (i_data_counter < IDX_W'(CMD_LEN)) begin
                w_data_nxt  = w_rom_byte;
                w_ctrl_nxt  = CTRL_CMD;
                w_state_nxt = S_HOLD;
            end else if (i_data_counter <= IDX_W'(LAST_IDX)) begin
                w_rd_en_nxt   = 1'b1;
                w_rd_addr_nxt = FB_AW'(i_data_counter - IDX_W'(CMD_LEN));
                w_state_nxt   = S_FETCH;
            end else begin
                w_data_nxt  = 8'h00;
                w_ctrl_nxt  = CTRL_CMD;
                w_state_nxt = S_HOLD;
            end
        end else if (r_state == S_FETCH) begin
            // Strobe cycle: RAM samples the address; next cycle its output is valid
            if (!r_fb_rd_en) begin
                w_data_nxt  = i_fb_rd_data;
                w_ctrl_nxt  = CTRL_DATA;
                w_state_nxt = S_HOLD;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_CMD;
            r_idx_q        <= '0;
            r_data_byte    <= RST_BYTE;
            r_control_byte <= CTRL_CMD;
            r_fb_rd_en     <= 1'b0;
            r_fb_rd_addr   <= '0;
            r_init_done    <= 1'b0;
            r_frame_done   <= 1'b0;
            r_seq_err      <= 1'b0;
            r_continue_bit <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_idx_q        <= w_idx_nxt;
            r_data_byte    <= w_data_nxt;
            r_control_byte <= w_ctrl_nxt;
            r_fb_rd_en     <= w_rd_en_nxt;
            r_fb_rd_addr   <= w_rd_addr_nxt;
            r_init_done    <= w_init_nxt;
            r_frame_done   <= w_frame_nxt;
            r_seq_err      <= w_err_nxt;
            r_continue_bit <= i_enable;
        end
    end

    assign o_addr_byte    = I2C_ADDR;
    assign o_read_write   = 1'b0;
    assign o_control_byte = r_control_byte;
    assign o_data_byte    = r_data_byte;
    assign o_continue_bit = r_continue_bit;
    assign o_fb_rd_en     = r_fb_rd_en;
    assign o_fb_rd_addr   = r_fb_rd_addr;
    assign o_init_done    = r_init_done;
    assign o_frame_done   = r_frame_done;
    assign o_seq_err      = r_seq_err;

endmodule

// File: tb/tb_oled_frame_sequencer.sv
// Self-checking bench: directed table, fetch-abort/reset sequences, random walk vs. model.
module tb_oled_frame_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [9:0] data_counter = '0;
    logic [6:0] addr_byte;
    logic       read_write;
    logic [7:0] control_byte;
    logic [7:0] data_byte;
    logic       continue_bit;
    logic       fb_rd_en;
    logic [8:0] fb_rd_addr;
    logic [7:0] fb_rd_data = '0;
    logic       init_done;
    logic       frame_done;
    logic       seq_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mem [512];
    logic [7:0] init_rom [26] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h1F, 8'hD3, 8'h00, 8'h40,
                                  8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h02,
                                  8'h81, 8'h8F, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6,
                                  8'h2E, 8'hAF};
    logic [7:0] addr_rom [6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h03};

    int m_idx;
    bit m_init;

    oled_frame_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_enable       (enable),
        .i_data_counter (data_counter),
        .o_addr_byte    (addr_byte),
        .o_read_write   (read_write),
        .o_control_byte (control_byte),
        .o_data_byte    (data_byte),
        .o_continue_bit (continue_bit),
        .o_fb_rd_en     (fb_rd_en),
        .o_fb_rd_addr   (fb_rd_addr),
        .i_fb_rd_data   (fb_rd_data),
        .o_init_done    (init_done),
        .o_frame_done   (frame_done),
        .o_seq_err      (seq_err)
    );

    always #5 clk = ~clk;

    // Synchronous framebuffer RAM: data valid one clock after the read strobe
    always @(posedge clk) begin
        if (fb_rd_en) fb_rd_data <= mem[fb_rd_addr];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst data_byte", 32'(data_byte), 32'h AE);
        chk("rst control_byte", 32'(control_byte), 32'h00);
        chk("rst continue_bit", 32'(continue_bit), 32'h0);
        chk("rst fb_rd_en", 32'(fb_rd_en), 32'h0);
        chk("rst fb_rd_addr", 32'(fb_rd_addr), 32'h0);
        chk("rst init_done", 32'(init_done), 32'h0);
        chk("rst frame_done", 32'(frame_done), 32'h0);
        chk("rst seq_err", 32'(seq_err), 32'h0);
        chk("addr_byte", 32'(addr_byte), 32'h3C);
        chk("read_write", 32'(read_write), 32'h0);
    endtask

    // Apply a changed index and check the full response timeline
    task automatic step(input int i, input logic [7:0] eb, input logic [7:0] ec,
                        input bit efr, input bit eer, input bit ein);
        bit is_fb;
        is_fb = (i >= 32) && (i <= 543);
        @(negedge clk);
        data_counter = 10'(i);
        @(posedge clk); #1;
        chk("frame_done", 32'(frame_done), 32'(efr));
        chk("seq_err", 32'(seq_err), 32'(eer));
        chk("init_done", 32'(init_done), 32'(ein));
        chk("fb_rd_en strobe", 32'(fb_rd_en), 32'(is_fb));
        if (is_fb) begin
            chk("fb_rd_addr", 32'(fb_rd_addr), 32'(i - 32));
            @(posedge clk); #1;
            chk("fb_rd_en drop", 32'(fb_rd_en), 32'h0);
            chk("pulse width", 32'({frame_done, seq_err}), 32'h0);
            @(posedge clk); #1;
        end
        chk("data_byte", 32'(data_byte), 32'(eb));
        chk("control_byte", 32'(control_byte), 32'(ec));
    endtask

    function automatic logic [7:0] model_byte(input int i);
        if (i < 26)       return init_rom[i];
        else if (i < 32)  return addr_rom[i - 26];
        else if (i <= 543) return mem[i - 32];
        else              return 8'h00;
    endfunction

    // Reference model: derives expectations from the index rules, then applies the step
    task automatic model_step(input int i);
        logic [7:0] eb;
        logic [7:0] ec;
        bit efr;
        bit eer;
        eb = model_byte(i);
        ec = ((i >= 32) && (i <= 543)) ? 8'h40 : 8'h00;
        efr = (m_idx == 543) && (i == 26);
        eer = !efr && ((i != m_idx + 1) || (i > 543));
        if (i >= 26) m_init = 1'b1;
        m_idx = i;
        step(i, eb, ec, efr, eer, m_init);
    endtask

    typedef struct {
        int         idx;
        logic [7:0] eb;
        logic [7:0] ec;
        bit         fr;
        bit         er;
        bit         ini;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int pick;
        int nxt;
        logic [7:0] hold_b;

        for (int k = 0; k < 512; k++) mem[k] = 8'($urandom);
        mem[0] = 8'h5A;
        mem[1] = 8'h11;
        mem[2] = 8'h22;
        mem[3] = 8'h33;

        vecs[0]  = '{25,  8'hAF,     8'h00, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{26,  8'h21,     8'h00, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{31,  8'h03,     8'h00, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{32,  8'h5A,     8'h40, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{543, mem[511],  8'h40, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{26,  8'h21,     8'h00, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{540, mem[508],  8'h40, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{100, mem[68],   8'h40, 1'b0, 1'b1, 1'b1};
        vecs[8]  = '{101, mem[69],   8'h40, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{700, 8'h00,     8'h00, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{0,   8'hAE,     8'h00, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{1,   8'hD5,     8'h00, 1'b0, 1'b0, 1'b1};

        // Reset with index held at 0
        #12;
        chk_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle data_byte", 32'(data_byte), 32'hAE);
        chk("idle continue_bit", 32'(continue_bit), 32'h0);
        @(negedge clk);
        enable = 1'b1;
        @(posedge clk); #1;
        chk("continue_bit follows enable", 32'(continue_bit), 32'h1);

        foreach (vecs[k]) step(vecs[k].idx, vecs[k].eb, vecs[k].ec, vecs[k].fr, vecs[k].er, vecs[k].ini);

        // Unchanged index: outputs hold and no pulses
        hold_b = data_byte;
        repeat (3) begin
            @(posedge clk); #1;
            chk("hold data_byte", 32'(data_byte), 32'(hold_b));
            chk("hold pulses", 32'({frame_done, seq_err, fb_rd_en}), 32'h0);
        end

        // Fetch abort: 33 -> 34 -> 35 back to back, only RAM[3] may land
        m_idx = 1;
        m_init = 1'b1;
        model_step(32);
        model_step(33);
        @(negedge clk); data_counter = 10'd34;
        @(posedge clk); #1;
        chk("abort addr 34", 32'(fb_rd_addr), 32'd2);
        @(negedge clk); data_counter = 10'd35;
        @(posedge clk); #1;
        chk("abort addr 35", 32'(fb_rd_addr), 32'd3);
        chk("abort strobe", 32'(fb_rd_en), 32'h1);
        chk("abort seq_err", 32'(seq_err), 32'h0);
        @(posedge clk); #1;
        chk("abort no stale data", 32'(data_byte), 32'h11);
        @(posedge clk); #1;
        chk("abort data_byte", 32'(data_byte), 32'h33);
        chk("abort control_byte", 32'(control_byte), 32'h40);
        m_idx = 35;

        // Randomised walk through the index space
        for (int n = 0; n < 300; n++) begin
            pick = $urandom_range(0, 99);
            if (m_idx == 543 && pick < 80) nxt = 26;
            else if (m_idx < 543 && pick < 70) nxt = m_idx + 1;
            else if (pick < 85) nxt = 543;
            else if (pick < 92) nxt = $urandom_range(544, 1023);
            else nxt = $urandom_range(0, 543);
            if (m_idx == 1023 && nxt == 0) nxt = 5;
            if (nxt == m_idx) nxt = (m_idx == 543) ? 26 : 7;
            model_step(nxt);
            if ((n % 10) == 0) begin
                @(negedge clk);
                enable = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                chk("continue_bit random", 32'(continue_bit), 32'(enable));
                chk("idle pulses", 32'({frame_done, seq_err}), 32'h0);
            end
        end

        // Asynchronous reset in the middle of a fetch, then resync
        step(36 + 0, mem[4], 8'h40, 1'b0, (m_idx != 35), 1'b1);
        @(negedge clk); data_counter = 10'd40;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        data_counter = 10'd0;
        @(negedge clk);
        rst_n = 1'b1;
        m_idx = 0;
        m_init = 1'b0;
        model_step(40);
        model_step(41);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
